buzzer_pattern_arbiter: RTL and testbench

//   Shares the single PmodAMP2 buzzer between NUM_REQ alert sources. Fixed-priority

---
 rtl/buzzer_pkg.sv | 23 ++
 rtl/buzzer_tone_gen.sv | 35 +++
 rtl/buzzer_pattern_arbiter.sv | 173 +++++++++++++++++
 tb/tb_buzzer_pattern_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer pattern arbiter and its tone generator.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MIN_HALF = 2;   // shortest legal tone half-period, cycles
  localparam int unsigned MS_W     = 10;  // width of on_ms / off_ms and the ms counter

  // Clock cycles per duration tick; the arbiter names the result MS_CYCLES.
  function automatic int unsigned ms_cycles(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int unsigned pre_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator: toggles every half_per cycles while en is high,
// and holds counter and output cleared while en is low.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned HALF_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [HALF_W-1:0] half_per,
  output logic              audio
);

  logic [HALF_W-1:0] cnt;
  logic              tone_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt    <= '0;
      tone_q <= 1'b0;
    end else if (cnt == half_per - HALF_W'(1)) begin
      cnt    <= '0;
      tone_q <= ~tone_q;
    end else begin
      cnt <= cnt + HALF_W'(1);
    end
  end

  // Gating keeps the pin quiet on the cycle the tone is switched off.
  assign audio = en & tone_q;

endmodule

// File: rtl/buzzer_pattern_arbiter.sv
// Fixed-priority owner of the PmodAMP2 buzzer: grants one alert source and plays its
// ON/OFF beep pattern. Define BUZZ_PREEMPT_EN to let higher-priority requests abort a pattern.
module buzzer_pattern_arbiter
  import buzzer_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned HALF_W  = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*HALF_W-1:0] req_half_per,
  input  logic [NUM_REQ*4-1:0]      req_beeps,
  input  logic [MS_W-1:0]           on_ms,
  input  logic [MS_W-1:0]           off_ms,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      audio_out,
  output logic                      amp_gain,
  output logic                      amp_shdn
);

  localparam int unsigned       MS_CYCLES = ms_cycles(CLK_HZ, TICK_HZ);
  localparam int unsigned       PRE_W     = pre_width(MS_CYCLES);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MS_CYCLES - 1);

  state_t              state;
  logic [HALF_W-1:0]   half_lat;
  logic [3:0]          beeps_left;
  logic [MS_W-1:0]     on_len;
  logic [MS_W-1:0]     off_len;
  logic [PRE_W-1:0]    pre_cnt;
  logic [MS_W-1:0]     ms_cnt;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [HALF_W-1:0]   win_half;
  logic [3:0]          win_beeps;
  logic                preempt;
  logic                ms_edge;
  logic                on_end;
  logic                off_end;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    win_onehot = '0;
    win_half   = '0;
    win_beeps  = '0;
    // Descending scan: the lowest set index is assigned last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_half      = req_half_per[i*HALF_W +: HALF_W];
        win_beeps     = req_beeps[i*4 +: 4];
      end
    end
    if (win_half < HALF_W'(MIN_HALF)) win_half = HALF_W'(MIN_HALF);
  end

`ifdef BUZZ_PREEMPT_EN
  // grant is one-hot, so grant-1 masks exactly the higher-priority indices.
  assign preempt = |(req & (grant - NUM_REQ'(1)));
`else
  assign preempt = 1'b0;
`endif

  assign ms_edge = (pre_cnt == PRE_LAST);
  assign on_end  = ms_edge && (ms_cnt == on_len - MS_W'(1));
  assign off_end = (off_len == '0) || (ms_edge && (ms_cnt == off_len - MS_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      amp_shdn   <= 1'b0;
      half_lat   <= '0;
      beeps_left <= '0;
      on_len     <= '0;
      off_len    <= '0;
      pre_cnt    <= '0;
      ms_cnt     <= '0;
    end else begin
      done <= '0;
      if (ms_edge) begin
        pre_cnt <= '0;
        ms_cnt  <= ms_cnt + MS_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end

      case (state)
        IDLE: begin
          pre_cnt <= '0;
          ms_cnt  <= '0;
          if (|req) begin
            grant      <= win_onehot;
            half_lat   <= win_half;
            beeps_left <= win_beeps;
            on_len     <= (on_ms == '0) ? MS_W'(1) : on_ms;
            off_len    <= off_ms;
            busy       <= 1'b1;
            if (win_beeps == 4'd0) begin
              state <= DONE;
              done  <= win_onehot;
            end else begin
              state    <= ON;
              amp_shdn <= 1'b1;
            end
          end
        end

        ON: begin
          if (preempt) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            amp_shdn <= 1'b0;
          end else if (on_end) begin
            state   <= OFF;
            pre_cnt <= '0;
            ms_cnt  <= '0;
          end
        end

        OFF: begin
          if (preempt) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            amp_shdn <= 1'b0;
          end else if (off_end) begin
            beeps_left <= beeps_left - 4'd1;
            pre_cnt    <= '0;
            ms_cnt     <= '0;
            if (beeps_left > 4'd1) begin
              state <= ON;
            end else begin
              state    <= DONE;
              done     <= grant;
              amp_shdn <= 1'b0;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  buzzer_tone_gen #(
    .HALF_W (HALF_W)
  ) u_tone (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ON),
    .half_per (half_lat),
    .audio    (audio_out)
  );

  assign amp_gain = 1'b1;

endmodule

// File: tb/tb_buzzer_pattern_arbiter.sv
// Self-checking bench for buzzer_pattern_arbiter at 10 cycles per ms: table vectors,
// hand sequences for priority/reset/preemption, and randomized checking against a pattern model.
module tb_buzzer_pattern_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CLK_HZ  = 10_000;
  localparam int TICK_HZ = 1000;
  localparam int HALF_W  = 17;
  localparam int MS      = CLK_HZ / TICK_HZ;
`ifdef BUZZ_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*HALF_W-1:0] req_half_per;
  logic [NUM_REQ*4-1:0]      req_beeps;
  logic [9:0]                on_ms;
  logic [9:0]                off_ms;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic                      audio_out;
  logic                      amp_gain;
  logic                      amp_shdn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buzzer_pattern_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .HALF_W  (HALF_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_half_per (req_half_per),
    .req_beeps    (req_beeps),
    .on_ms        (on_ms),
    .off_ms       (off_ms),
    .grant        (grant),
    .done         (done),
    .busy         (busy),
    .audio_out    (audio_out),
    .amp_gain     (amp_gain),
    .amp_shdn     (amp_shdn)
  );

  typedef struct {
    logic [3:0] req;
    int         half;
    int         beeps;
    int         on;
    int         off;
    logic [3:0] grant;
    int         len;
    int         rises;
    int         high;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {grant, done, busy, audio_out, amp_gain, amp_shdn};
  endfunction

  task automatic set_all(input logic [3:0] r, input int half, input int beeps,
                         input int on, input int off);
    req = r;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_half_per[i*HALF_W +: HALF_W] = 17'(half);
      req_beeps[i*4 +: 4]              = 4'(beeps);
    end
    on_ms  = 10'(on);
    off_ms = 10'(off);
  endtask

  // Waits (bounded) for a done pulse; returns cycles waited.
  task automatic wait_done(input string name, output int k);
    k = 0;
    while (done == '0 && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) check({name, " done timeout"}, 32'(k), 32'(0));
  endtask

  task automatic run_pattern(input string name, input vec_t v);
    int   k;
    int   rises;
    int   high;
    logic prev_a;
    set_all(v.req, v.half, v.beeps, v.on, v.off);
    tick();
    check({name, " grant"}, 32'(grant), 32'(v.grant));
    req    = '0;
    k      = 0;
    rises  = 0;
    high   = 0;
    prev_a = 1'b0;
    while (done == '0 && k < 3000) begin
      if (audio_out && !prev_a) rises++;
      if (audio_out) high++;
      prev_a = audio_out;
      tick();
      k++;
    end
    check({name, " length"}, 32'(k), 32'(v.len));
    check({name, " rises"}, 32'(rises), 32'(v.rises));
    check({name, " high cycles"}, 32'(high), 32'(v.high));
    check({name, " done state"}, 32'({grant, done, busy, audio_out, amp_shdn}),
          32'({v.grant, v.grant, 1'b1, 1'b0, 1'b0}));
    tick();
    check({name, " idle after"}, 32'(outs()), 32'(12'b0000_0000_0010));
  endtask

  // Reference model: owner and cycle offset since grant; outputs follow from pattern arithmetic.
  int m_owner = -1;
  int m_k, m_half, m_beeps, m_on, m_off, m_period;

  task automatic model_step();
    int hv;
    if (rst) begin
      m_owner = -1;
    end else if (m_owner < 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) m_owner = i;
      if (m_owner >= 0) begin
        hv       = int'(req_half_per[m_owner*HALF_W +: HALF_W]);
        m_half   = (hv < 2) ? 2 : hv;
        m_beeps  = int'(req_beeps[m_owner*4 +: 4]);
        m_on     = ((on_ms == 0) ? 1 : int'(on_ms)) * MS;
        m_off    = (off_ms == 0) ? 1 : int'(off_ms) * MS;
        m_period = m_on + m_off;
        m_k      = 0;
      end
    end else if (PREEMPT && m_k < m_beeps * m_period &&
                 (int'(req) & ((1 << m_owner) - 1)) != 0) begin
      m_owner = -1;
    end else if (m_k >= m_beeps * m_period) begin
      m_owner = -1;
    end else begin
      m_k++;
    end
  endtask

  function automatic logic [11:0] model_outs();
    logic [3:0] g;
    logic       playing;
    logic       a;
    int         j;
    if (m_owner < 0) return 12'b0000_0000_0010;
    g       = 4'(1 << m_owner);
    playing = (m_k < m_beeps * m_period);
    j       = playing ? (m_k % m_period) : 0;
    a       = playing && (j < m_on) && (((j / m_half) % 2) == 1);
    return {g, playing ? 4'b0 : g, 1'b1, a, 1'b1, playing};
  endfunction

  initial begin
    int k;

    vecs[0] = '{4'b0010, 5, 2, 3, 2, 4'b0010, 100, 6, 30};
    vecs[1] = '{4'b0001, 0, 1, 1, 0, 4'b0001, 11, 2, 4};
    vecs[2] = '{4'b1000, 1, 3, 0, 1, 4'b1000, 60, 6, 12};
    vecs[3] = '{4'b0100, 5, 0, 3, 2, 4'b0100, 0, 0, 0};
    vecs[4] = '{4'b0110, 3, 1, 2, 1, 4'b0010, 30, 3, 9};
    vecs[5] = '{4'b1111, 7, 1, 1, 0, 4'b0001, 11, 1, 3};
    vecs[6] = '{4'b0001, 4, 15, 1, 0, 4'b0001, 165, 15, 60};

    rst = 1'b1;
    set_all(4'b0000, 0, 0, 0, 0);
    tick();
    tick();
    check("reset outputs", 32'(outs()), 32'(12'b0000_0000_0010));
    rst = 1'b0;
    tick();
    check("idle no req", 32'(outs()), 32'(12'b0000_0000_0010));

    for (int i = 0; i < 7; i++) run_pattern($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests 0 and 2: 0 first, 2 after req[0] drops.
    set_all(4'b0101, 2, 1, 1, 0);
    tick();
    check("pri first grant", 32'(grant), 32'(4'b0001));
    wait_done("pri first", k);
    check("pri first done", 32'(done), 32'(4'b0001));
    req = 4'b0100;
    tick();
    check("pri idle gap", 32'({grant, busy}), 32'(0));
    tick();
    check("pri second grant", 32'(grant), 32'(4'b0100));
    req = 4'b0000;
    wait_done("pri second", k);
    check("pri second done", 32'(done), 32'(4'b0100));
    tick();

    // Reset in the middle of an ON phase.
    set_all(4'b0010, 5, 2, 3, 2);
    tick();
    req = 4'b0000;
    repeat (12) tick();
    check("mid-on playing", 32'({amp_shdn, busy}), 32'(2'b11));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid-on outputs", 32'(outs()), 32'(12'b0000_0000_0010));
    tick();
    check("rst no done", 32'(outs()), 32'(12'b0000_0000_0010));
    run_pattern("after rst", vecs[0]);

    // Owner 2 in ON, then request 0 rises.
    set_all(4'b0100, 5, 2, 3, 2);
    tick();
    check("pre owner grant", 32'(grant), 32'(4'b0100));
    req = 4'b0000;
    repeat (5) tick();
    req = 4'b0001;
    tick();
    if (PREEMPT) begin
      check("pre abort idle", 32'(outs()), 32'(12'b0000_0000_0010));
      tick();
      check("pre new grant", 32'(grant), 32'(4'b0001));
      req = 4'b0000;
      wait_done("pre new", k);
      check("pre new done", 32'(done), 32'(4'b0001));
    end else begin
      check("wait owner kept", 32'(grant), 32'(4'b0100));
      wait_done("wait owner", k);
      check("wait owner done", 32'(done), 32'(4'b0100));
      tick();
      tick();
      check("wait then grant", 32'(grant), 32'(4'b0001));
      req = 4'b0000;
      wait_done("wait second", k);
      check("wait second done", 32'(done), 32'(4'b0001));
    end
    tick();

    // Randomized traffic against the model.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    m_owner = -1;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        req_half_per[i*HALF_W +: HALF_W] = 17'($urandom_range(0, 6));
        req_beeps[i*4 +: 4]              = 4'($urandom_range(0, 3));
      end
      on_ms  = 10'($urandom_range(0, 2));
      off_ms = 10'($urandom_range(0, 2));
      rst    = ($urandom_range(0, 299) == 0);
      model_step();
      tick();
      check($sformatf("random cycle %0d", c), 32'(outs()), 32'(model_outs()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
